sipo_shift_rx: RTL and testbench
================================

Name: sipo_shift_rx

Overview:
- Serial-in/parallel-out receiver for the team's LSB-first serial byte link: the receive end of the serial shifter.
- Samples one bit per clock while the bit qualifier is high and assembles DATA_W-bit words.
- Presents each completed word on a valid/ready output register.
- Flags truncated frames and words dropped because the output is full.

Parameters:
- DATA_W, 8, bits per frame/word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- serial_i  input  1  serial data; meaningful only when bit_vld_i=1; idle level high.
- bit_vld_i  input  1  high for exactly the cycles carrying frame bits; a frame is DATA_W consecutive high cycles.
- data_o  output  DATA_W  received word, LSB = first bit received.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts data_o when valid_o & ready_i at a rising edge.
- busy_o  output  1  frame reception in progress (state RECEIVE).
- frame_err_o  output  1  one-cycle pulse: frame truncated.
- overrun_o  output  1  one-cycle pulse: completed word dropped.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; shift register, bit count and data_o = 0.
  - valid_o, busy_o, frame_err_o and overrun_o = 0.
  - Reset mid-frame discards the partial word silently; no error pulse.
- Shift rule: on every sampled bit, shreg <= {serial_i, shreg[DATA_W-1:1]}. After DATA_W samples, the first bit is in bit 0.
- Counter: cnt is $clog2(DATA_W+1) bits wide, holds the number of bits sampled, and never wraps.
- State IDLE:
  - bit_vld_i=1: sample bit, cnt<=1, go to RECEIVE.
  - Otherwise hold; serial_i is ignored.
- State RECEIVE:
  - bit_vld_i=1 and cnt<DATA_W-1: sample bit, cnt<=cnt+1.
  - bit_vld_i=1 and cnt==DATA_W-1: final bit. The completed word {serial_i, shreg[DATA_W-1:1]} goes to the output stage at this edge. cnt<=0, go to IDLE.
  - bit_vld_i=0: truncated frame. Pulse frame_err_o for 1 cycle (registered, visible the cycle after the gap), discard the partial word, cnt<=0, go to IDLE. The output stage is untouched.
- Output stage (single register):
  - Latency: data_o/valid_o update on the edge that samples the last bit, so they are visible the cycle after the last bit is presented.
  - Completion with valid_o=0: load data_o, valid_o<=1.
  - Completion with valid_o=1 and ready_i=1: old word consumed, new word loaded, valid_o stays 1, no overrun.
  - Completion with valid_o=1 and ready_i=0: new word dropped, data_o unchanged, overrun_o pulses 1 cycle.
  - No completion with valid_o & ready_i: valid_o<=0. data_o keeps its last value.
  - data_o is stable while valid_o=1 and ready_i=0.
- Back-to-back frames:
  - bit_vld_i may stay high across frame boundaries; the next frame's first bit is sampled in IDLE the cycle after completion.
  - A gap of any length between frames is legal and is not an error.
- busy_o = (state==RECEIVE). It is low in the cycle after the final bit and after a truncation.
- frame_err_o and overrun_o never assert in the same cycle.

Test Plan:
- Single frame (DATA_W=8), 0xA5 sent LSB-first: bits 1,0,1,0,0,1,0,1 on 8 consecutive bit_vld_i cycles, ready_i=0 → valid_o=1 and data_o=0xA5 the cycle after bit 8; they hold until ready_i=1, then valid_o=0 the next cycle.
- Back-to-back frames, ready_i tied 1: 0x3C then 0xFF over 16 continuous bit_vld_i cycles → data_o=0x3C for 1 cycle after bit 8, then 0xFF after bit 16; valid_o is high for exactly those 2 cycles; no error pulses.
- Overrun: 0x12 received with ready_i=0, then 0x34 received → overrun_o pulses once, data_o stays 0x12. Raising ready_i in the cycle of 0x56's last bit yields data_o=0x56 with no overrun.
- Truncation: 5 bits sent, then bit_vld_i=0 → frame_err_o single pulse, valid_o unchanged, busy_o=0. The next full frame 0x81 is received correctly.
- Reset mid-frame: rst=1 after 4 bits → all outputs 0 next cycle, no frame_err_o. A subsequent 0x7E frame is received exactly.
- Idle noise: serial_i toggling with bit_vld_i=0 for 20 cycles → no valid_o, busy_o or error activity.

Source files
------------

// File: rtl/sipo_shift_rx_if.sv
// Serial byte link receive-side bundle: serial bit stream in, parallel word out
// with a valid/ready handshake toward the consumer.
interface sipo_shift_rx_if #(
    parameter int DATA_W = 8
);
    logic              serial_i;
    logic              bit_vld_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;

    // master: the serial source plus the word consumer; slave: the receiver
    modport master (
        output serial_i, bit_vld_i, ready_i,
        input  data_o, valid_o
    );

    modport slave (
        input  serial_i, bit_vld_i, ready_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/sipo_shift_rx.sv
// LSB-first serial-in/parallel-out receiver: assembles DATA_W-bit frames and
// holds each completed word in a single valid/ready output register.
module sipo_shift_rx #(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    sipo_shift_rx_if.slave  rx,
    output logic            busy_o,
    output logic            frame_err_o,
    output logic            overrun_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    logic [DATA_W-1:0]  shifted;
    logic               complete;

    // New bits enter at the top so the first bit lands in bit 0 after DATA_W shifts
    assign shifted = {rx.serial_i, shreg_q[DATA_W-1:1]};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx.bit_vld_i) begin
                    shreg_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = RECEIVE;
                end
            end
            RECEIVE: begin
                if (rx.bit_vld_i) begin
                    shreg_d = shifted;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    frame_err_d = 1'b1;
                    shreg_d     = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full register that is not being drained this edge drops the new word
        if (complete) begin
            if (!valid_q || rx.ready_i) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.data_o    = data_q;
    assign rx.valid_o   = valid_q;
    assign busy_o       = (state_q == RECEIVE);
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_sipo_shift_rx.sv
// Directed bench for sipo_shift_rx: single frame, back-to-back, overrun,
// truncation, mid-frame reset and idle noise, with hand-computed expectations.
module tb_sipo_shift_rx;
    localparam int DATA_W = 8;

    logic clk;
    logic rst;
    logic busy_o;
    logic frame_err_o;
    logic overrun_o;

    int n_compared;
    int n_mismatched;
    int valid_cnt;
    int busy_cnt;
    int ferr_cnt;
    int ovr_cnt;

    sipo_shift_rx_if #(.DATA_W(DATA_W)) bus ();

    sipo_shift_rx #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activity counters, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.valid_o)  valid_cnt++;
        if (busy_o)       busy_cnt++;
        if (frame_err_o)  ferr_cnt++;
        if (overrun_o)    ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        busy_cnt  = 0;
        ferr_cnt  = 0;
        ovr_cnt   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive bits first..last of w, LSB-first, one per clock with the qualifier high
    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.serial_i  = w[i];
            bus.bit_vld_i = 1'b1;
            tick();
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        clear_counts();
        rst           = 1'b1;
        bus.serial_i  = 1'b1;
        bus.bit_vld_i = 1'b0;
        bus.ready_i   = 1'b0;
        tick();
        tick();
        check("reset_data", 32'(bus.data_o), 32'h0);
        check("reset_valid", 32'(bus.valid_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_ferr", 32'(frame_err_o), 32'h0);
        check("reset_ovr", 32'(overrun_o), 32'h0);
        rst = 1'b0;
        tick();

        // Single frame 0xA5, consumer stalled
        send_bits(8'hA5, 0, 6);
        check("a5_busy_mid", 32'(busy_o), 32'h1);
        check("a5_valid_mid", 32'(bus.valid_o), 32'h0);
        send_bits(8'hA5, 7, 7);
        bus.bit_vld_i = 1'b0;
        bus.serial_i  = 1'b1;
        check("a5_valid", 32'(bus.valid_o), 32'h1);
        check("a5_data", 32'(bus.data_o), 32'hA5);
        check("a5_busy_done", 32'(busy_o), 32'h0);
        tick();
        tick();
        tick();
        check("a5_hold_valid", 32'(bus.valid_o), 32'h1);
        check("a5_hold_data", 32'(bus.data_o), 32'hA5);
        bus.ready_i = 1'b1;
        tick();
        check("a5_consumed", 32'(bus.valid_o), 32'h0);
        check("a5_data_kept", 32'(bus.data_o), 32'hA5);

        // Back-to-back 0x3C, 0xFF with ready tied high
        clear_counts();
        send_bits(8'h3C, 0, 7);
        check("b2b_data0", 32'(bus.data_o), 32'h3C);
        check("b2b_valid0", 32'(bus.valid_o), 32'h1);
        send_bits(8'hFF, 0, 0);
        check("b2b_drained", 32'(bus.valid_o), 32'h0);
        send_bits(8'hFF, 1, 7);
        bus.bit_vld_i = 1'b0;
        check("b2b_data1", 32'(bus.data_o), 32'hFF);
        check("b2b_valid1", 32'(bus.valid_o), 32'h1);
        tick();
        check("b2b_valid_end", 32'(bus.valid_o), 32'h0);
        check("b2b_valid_cycles", 32'(valid_cnt), 32'd2);
        check("b2b_no_ferr", 32'(ferr_cnt), 32'd0);
        check("b2b_no_ovr", 32'(ovr_cnt), 32'd0);

        // Overrun: 0x12 held, 0x34 dropped, 0x56 accepted by same-edge drain
        bus.ready_i = 1'b0;
        clear_counts();
        send_bits(8'h12, 0, 7);
        check("ovr_first", 32'(bus.data_o), 32'h12);
        send_bits(8'h34, 0, 7);
        check("ovr_pulse", 32'(overrun_o), 32'h1);
        check("ovr_data_kept", 32'(bus.data_o), 32'h12);
        send_bits(8'h56, 0, 6);
        check("ovr_pulse_gone", 32'(overrun_o), 32'h0);
        bus.ready_i = 1'b1;
        send_bits(8'h56, 7, 7);
        bus.bit_vld_i = 1'b0;
        bus.ready_i   = 1'b0;
        check("ovr_swap_data", 32'(bus.data_o), 32'h56);
        check("ovr_swap_valid", 32'(bus.valid_o), 32'h1);
        check("ovr_swap_no_pulse", 32'(overrun_o), 32'h0);
        tick();
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check("ovr_drained", 32'(bus.valid_o), 32'h0);

        // Truncation after 5 bits, then a clean 0x81
        clear_counts();
        send_bits(8'hC3, 0, 4);
        check("trunc_busy", 32'(busy_o), 32'h1);
        bus.bit_vld_i = 1'b0;
        tick();
        check("trunc_ferr", 32'(frame_err_o), 32'h1);
        check("trunc_busy_low", 32'(busy_o), 32'h0);
        check("trunc_valid", 32'(bus.valid_o), 32'h0);
        check("trunc_no_ovr", 32'(overrun_o), 32'h0);
        tick();
        check("trunc_ferr_low", 32'(frame_err_o), 32'h0);
        check("trunc_ferr_count", 32'(ferr_cnt), 32'd1);
        send_bits(8'h81, 0, 7);
        bus.bit_vld_i = 1'b0;
        check("trunc_next_data", 32'(bus.data_o), 32'h81);
        check("trunc_next_valid", 32'(bus.valid_o), 32'h1);

        // Reset in the middle of a frame
        clear_counts();
        send_bits(8'hFF, 0, 3);
        rst           = 1'b1;
        bus.bit_vld_i = 1'b0;
        tick();
        check("mrst_data", 32'(bus.data_o), 32'h0);
        check("mrst_valid", 32'(bus.valid_o), 32'h0);
        check("mrst_busy", 32'(busy_o), 32'h0);
        check("mrst_ferr", 32'(frame_err_o), 32'h0);
        rst = 1'b0;
        tick();
        check("mrst_no_ferr", 32'(ferr_cnt), 32'd0);
        send_bits(8'h7E, 0, 7);
        bus.bit_vld_i = 1'b0;
        check("mrst_next_data", 32'(bus.data_o), 32'h7E);
        check("mrst_next_valid", 32'(bus.valid_o), 32'h1);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;

        // Idle noise on serial_i with the qualifier low
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            bus.serial_i = i[0];
            tick();
        end
        check("noise_valid", 32'(valid_cnt), 32'd0);
        check("noise_busy", 32'(busy_cnt), 32'd0);
        check("noise_ferr", 32'(ferr_cnt), 32'd0);
        check("noise_ovr", 32'(ovr_cnt), 32'd0);
        check("noise_data", 32'(bus.data_o), 32'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
